// File: rtl/rob_commit_unit_if.sv
// Issue / writeback / operand-query / commit-broadcast bundle of the reorder buffer.
// The ROB takes the slave side; the core pipeline (or a bench) takes the master side.
interface rob_commit_unit_if #(
    parameter int ADDR_W = 5
);
    logic              ROB_is_full;

    logic              alloc_en;
    logic [4:0]        alloc_rd;
    logic [ADDR_W-1:0] alloc_tag;

    logic              wb_en;
    logic [ADDR_W-1:0] wb_tag;
    logic [31:0]       wb_val;
    logic              wb_mispredict;
    logic [31:0]       wb_target;

    logic [ADDR_W-1:0] query1_tag;
    logic [ADDR_W-1:0] query2_tag;
    logic              query1_ready;
    logic              query2_ready;
    logic [31:0]       query1_val;
    logic [31:0]       query2_val;

    logic              commit_en;
    logic [ADDR_W-1:0] commit_Number;
    logic [4:0]        commit_rd;
    logic [31:0]       commit_val;
    logic              clear;
    logic [31:0]       clear_pc;

    modport master (
        input  ROB_is_full, alloc_tag,
        input  query1_ready, query2_ready, query1_val, query2_val,
        input  commit_en, commit_Number, commit_rd, commit_val, clear, clear_pc,
        output alloc_en, alloc_rd,
        output wb_en, wb_tag, wb_val, wb_mispredict, wb_target,
        output query1_tag, query2_tag
    );

    modport slave (
        output ROB_is_full, alloc_tag,
        output query1_ready, query2_ready, query1_val, query2_val,
        output commit_en, commit_Number, commit_rd, commit_val, clear, clear_pc,
        input  alloc_en, alloc_rd,
        input  wb_en, wb_tag, wb_val, wb_mispredict, wb_target,
        input  query1_tag, query2_tag
    );
endinterface

// File: rtl/rob_commit_unit.sv
// Reorder buffer: tagged allocation, writeback capture, in-order retirement, mispredict flush.
// Optional: define ROB_WB_BYPASS_EN so operand queries also see a same-cycle writeback.
module rob_commit_unit #(
    parameter int ADDR_W      = 5,
    parameter int FULL_MARGIN = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    rob_commit_unit_if.slave rob
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] FULL_THR = (ADDR_W + 1)'(DEPTH - FULL_MARGIN);

    typedef logic [ADDR_W-1:0] tag_t;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] misp_q;
    logic [4:0]       rd_q  [DEPTH];
    logic [31:0]      val_q [DEPTH];
    logic [31:0]      tgt_q [DEPTH];

    tag_t             head_q;
    tag_t             tail_q;
    logic [ADDR_W:0]  count_q;
    logic [ADDR_W:0]  count_d;

    logic             commit_en_q;
    tag_t             commit_num_q;
    logic [4:0]       commit_rd_q;
    logic [31:0]      commit_val_q;
    logic             clear_q;
    logic [31:0]      clear_pc_q;

    logic             alloc_ok;
    logic             wb_ok;
    logic             commit_fire;
    logic             flush;

    logic             q1_ready;
    logic             q2_ready;
    logic [31:0]      q1_val;
    logic [31:0]      q2_val;

    // All decisions look only at registered state, so a writeback cannot retire in its own cycle.
    assign alloc_ok    = rob.alloc_en && (count_q < DEPTH_C);
    assign wb_ok       = rob.wb_en && valid_q[rob.wb_tag];
    assign commit_fire = valid_q[head_q] && done_q[head_q];
    assign flush       = commit_fire && misp_q[head_q];

    always_comb begin
        count_d = count_q;
        if (alloc_ok && !commit_fire) begin
            count_d = count_q + (ADDR_W + 1)'(1);
        end else if (!alloc_ok && commit_fire) begin
            count_d = count_q - (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q      <= '0;
            done_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            commit_en_q  <= 1'b0;
            commit_num_q <= '0;
            commit_rd_q  <= '0;
            commit_val_q <= '0;
            clear_q      <= 1'b0;
            clear_pc_q   <= '0;
        end else if (rdy_in) begin
            commit_en_q <= commit_fire;
            clear_q     <= flush;
            if (commit_fire) begin
                commit_num_q <= head_q;
                commit_rd_q  <= rd_q[head_q];
                commit_val_q <= val_q[head_q];
            end
            if (flush) begin
                // Everything younger than the branch is on the wrong path, including this cycle's traffic.
                clear_pc_q <= tgt_q[head_q];
                valid_q    <= '0;
                done_q     <= '0;
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
            end else begin
                if (wb_ok) begin
                    done_q[rob.wb_tag] <= 1'b1;
                end
                if (alloc_ok) begin
                    valid_q[tail_q] <= 1'b1;
                    done_q[tail_q]  <= 1'b0;
                    tail_q          <= tail_q + tag_t'(1);
                end
                if (commit_fire) begin
                    valid_q[head_q] <= 1'b0;
                    head_q          <= head_q + tag_t'(1);
                end
                count_q <= count_d;
            end
        end
    end

    // Payload storage needs no reset: nothing reads it unless the entry is valid and done.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !flush) begin
            if (wb_ok) begin
                val_q[rob.wb_tag]  <= rob.wb_val;
                tgt_q[rob.wb_tag]  <= rob.wb_target;
                misp_q[rob.wb_tag] <= rob.wb_mispredict;
            end
            if (alloc_ok) begin
                rd_q[tail_q] <= rob.alloc_rd;
            end
        end
    end

    always_comb begin
        q1_ready = valid_q[rob.query1_tag] && done_q[rob.query1_tag];
        q1_val   = q1_ready ? val_q[rob.query1_tag] : 32'h0;
        q2_ready = valid_q[rob.query2_tag] && done_q[rob.query2_tag];
        q2_val   = q2_ready ? val_q[rob.query2_tag] : 32'h0;
`ifdef ROB_WB_BYPASS_EN
        if (rob.wb_en && (rob.wb_tag == rob.query1_tag)) begin
            q1_ready = 1'b1;
            q1_val   = rob.wb_val;
        end
        if (rob.wb_en && (rob.wb_tag == rob.query2_tag)) begin
            q2_ready = 1'b1;
            q2_val   = rob.wb_val;
        end
`else
`endif
    end

    assign rob.ROB_is_full   = (count_q >= FULL_THR);
    assign rob.alloc_tag     = tail_q;
    assign rob.query1_ready  = q1_ready;
    assign rob.query2_ready  = q2_ready;
    assign rob.query1_val    = q1_val;
    assign rob.query2_val    = q2_val;
    assign rob.commit_en     = commit_en_q;
    assign rob.commit_Number = commit_num_q;
    assign rob.commit_rd     = commit_rd_q;
    assign rob.commit_val    = commit_val_q;
    assign rob.clear         = clear_q;
    assign rob.clear_pc      = clear_pc_q;
endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer of the out-of-order core.
- Allocates one tagged entry per issued instruction and captures ALU writebacks by tag.
- Retires entries strictly in program order, one per cycle.
- Drives the commit broadcast bus (tag, value, rd) consumed by the reservation station and register file, and raises the pipeline-wide clear on a mispredicted branch.

Parameters:
- ADDR_W, 5, tag width; DEPTH = 2**ADDR_W entries (32).
- FULL_MARGIN, 2, free entries still left when ROB_is_full asserts (covers issue in flight).

Ports:
- clk_in  input  1  system clock; all state updates on posedge.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  global enable; when low, all state and outputs hold.
- ROB_is_full  output  1  combinational: count >= DEPTH-FULL_MARGIN.
- alloc_en  input  1  issue allocates an entry this cycle.
- alloc_rd  input  5  destination register of allocated instruction.
- alloc_tag  output  ADDR_W  combinational: current tail index; valid whenever not full.
- wb_en  input  1  ALU result valid.
- wb_tag  input  ADDR_W  ROB tag of the result.
- wb_val  input  32  result value.
- wb_mispredict  input  1  result belongs to a branch whose resolved direction differs from the fetch prediction.
- wb_target  input  32  correct next PC, meaningful when wb_mispredict=1.
- query1_tag, query2_tag  input  ADDR_W  operand tags looked up by issue.
- query1_ready, query2_ready  output  1  combinational: entry holds a finished value.
- query1_val, query2_val  output  32  combinational: that value (0 when not ready).
- commit_en  output  1  registered one-cycle pulse per retired entry.
- commit_Number  output  ADDR_W  tag of retired entry.
- commit_rd  output  5  destination register of retired entry.
- commit_val  output  32  value of retired entry.
- clear  output  1  registered one-cycle flush pulse.
- clear_pc  output  32  redirect PC, valid with clear.

Behaviour:
- Reset (rst_in=1 at posedge, regardless of rdy_in): head=tail=count=0; all valid/done bits cleared; commit_en=0, clear=0, commit_Number=0, commit_rd=0, commit_val=0, clear_pc=0.
- Per-entry state: valid, done, rd, val, mispredict, target.
- Allocation: alloc_en && count<DEPTH → entry[tail] gets valid=1, done=0, rd=alloc_rd; tail=(tail+1) mod DEPTH (wraps 31→0).
  - alloc_en at count==DEPTH is ignored; no state changes.
- Writeback: wb_en && entry[wb_tag].valid → done=1 and val/mispredict/target captured.
  - Writeback to an invalid entry is ignored.
- Commit: evaluated on registered state. If entry[head].valid && done, then at the posedge:
  - commit_en=1, commit_Number=head, commit_rd/commit_val from the entry;
  - entry invalidated; head++ (wraps).
  - Otherwise commit_en=0 that cycle.
  - Latency: writeback at edge N → earliest commit_en high after edge N+1.
- rd=0 entries still pulse commit_en (the RS needs the tag broadcast); the register file drops writes to x0.
- Mispredict: when the committing head has mispredict=1, the same edge also sets clear=1, clear_pc=target, and empties the ROB (head=tail=count=0, all valid cleared).
  - Any alloc or writeback presented in that cycle is discarded.
  - clear drops the next cycle.
- Count: +1 on accepted alloc, -1 on commit; simultaneous alloc and commit leaves count unchanged.
- rdy_in=0 (rst_in=0): nothing updates; commit_en and clear hold their last values.
- Query: ready = entry[tag].valid && done, with val = entry val. Bypass rule is under Optional Feature.

Optional Feature:
- ROB_WB_BYPASS_EN defined: query ready is also 1 when wb_en && wb_tag==query_tag in the same cycle, and val = wb_val. This closes the gap where issue would otherwise miss a same-cycle writeback.
- Not defined: only registered done bits answer queries.

Test Plan:
- Reset, then 3 allocs with rd=1,2,3 → alloc_tag 0,1,2; count=3; commit_en stays 0.
- Writeback tag1=0x22, then tag0=0x11 → no commit after tag1; commits in order tag0/0x11/rd1, then tag1/0x22/rd2, on consecutive cycles.
- 31 allocs with commits disabled → ROB_is_full=1 from count 30. Then alternate commit and alloc across the wrap → tags 31,0,1 issued in order; count never exceeds 32.
- Tag 2 written back with wb_mispredict=1, wb_target=0x1000, with tags 3–5 allocated → on tag 2 commit, clear=1 and clear_pc=0x1000 for exactly one cycle; then count=0 and alloc_tag=0.
- Query tag 4 in the same cycle as wb_en, wb_tag=4, wb_val=0xABCD → query_ready=1 and val=0xABCD with ROB_WB_BYPASS_EN; ready=0 without it; ready=1 with val 0xABCD the next cycle in both builds.
- rdy_in held low for 3 cycles mid-commit → commit_Number/commit_val frozen, no additional retirement; resumes with the next tag when rdy_in returns high.
